// File: rtl/aes_pkg.sv
// Shared AES-128 inverse-cipher types and constants.
package aes_pkg;

   typedef logic [127:0] aes_block_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      INIT  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } inv_seq_state_t;

   localparam int         NUM_ROUNDS   = 10;
   localparam logic [3:0] LAST_ROUND   = 4'(NUM_ROUNDS - 1);
   localparam logic [3:0] INIT_KEY_IDX = 4'(NUM_ROUNDS);

endpackage

// File: rtl/inv_round_sequencer_if.sv
// Host, key-store and inverse-datapath connections of the inverse round sequencer.
interface inv_round_sequencer_if;
   import aes_pkg::*;

   logic       i_start;
   aes_block_t i_cipher;
   logic       o_busy;
   logic       o_done;
   aes_block_t o_plain;
   logic [3:0] o_key_idx;
   aes_block_t i_key;
   logic       i_key_valid;
   aes_block_t o_round_data;
   aes_block_t i_sub_data;
   aes_block_t o_ark_data;
   logic [4:0] o_state;
   aes_block_t i_mix_data;

   modport master (
      output i_start, i_cipher, i_key, i_key_valid, i_sub_data, i_mix_data,
      input  o_busy, o_done, o_plain, o_key_idx, o_round_data, o_ark_data, o_state
   );

   modport slave (
      input  i_start, i_cipher, i_key, i_key_valid, i_sub_data, i_mix_data,
      output o_busy, o_done, o_plain, o_key_idx, o_round_data, o_ark_data, o_state
   );

endinterface

// File: rtl/inv_round_sequencer_add_round_key.sv
// AddRoundKey: bitwise 128-bit XOR of a state block with a round key.
module add_round_key
   import aes_pkg::*;
(
   input  aes_block_t data,
   input  aes_block_t key,
   output aes_block_t result
);

   assign result = data ^ key;

endmodule

// File: rtl/inv_round_sequencer.sv
// AES-128 inverse-cipher round sequencer: state register, round counter and handshakes.
//
// state | meaning
// IDLE  | waiting for i_start; plaintext of the last block held on o_plain
// INIT  | initial AddRoundKey with key 10
// ROUND | rounds 0..9, state <- inverse mix-columns return (bypassed in round 9)
// DONE  | one-cycle o_done pulse, then back to IDLE
module inv_round_sequencer
   import aes_pkg::*;
(
   input logic                  clk,
   input logic                  n_rst,
   inv_round_sequencer_if.slave bus
);

   localparam logic [1:0] ST_IDLE  = 2'(IDLE);
   localparam logic [1:0] ST_INIT  = 2'(INIT);
   localparam logic [1:0] ST_ROUND = 2'(ROUND);
   localparam logic [1:0] ST_DONE  = 2'(DONE);

   logic [1:0] fsm_q;
   aes_block_t state_q;
   logic [3:0] round_q;
   aes_block_t ark_in;
   aes_block_t ark_out;
   logic       in_init;
   logic       in_round;

   assign in_init  = (fsm_q == ST_INIT);
   assign in_round = (fsm_q == ST_ROUND);

   // A single XOR serves both the INIT whitening and the per-round key add.
   assign ark_in = in_init ? state_q : bus.i_sub_data;

   add_round_key u_add_round_key (
      .data   (ark_in),
      .key    (bus.i_key),
      .result (ark_out)
   );

   always_comb begin
      bus.o_key_idx = 4'd0;
      if (in_init) begin
         bus.o_key_idx = INIT_KEY_IDX;
      end else if (in_round) begin
         bus.o_key_idx = LAST_ROUND - round_q;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         fsm_q   <= ST_IDLE;
         state_q <= '0;
         round_q <= '0;
      end else begin
         case (fsm_q)
            ST_IDLE: begin
               if (bus.i_start) begin
                  fsm_q   <= ST_INIT;
                  state_q <= bus.i_cipher;
                  round_q <= '0;
               end
            end
            ST_INIT: begin
               if (bus.i_key_valid) begin
                  state_q <= ark_out;
                  fsm_q   <= ST_ROUND;
               end
            end
            ST_ROUND: begin
               if (bus.i_key_valid) begin
                  state_q <= bus.i_mix_data;
                  if (round_q == LAST_ROUND) begin
                     fsm_q <= ST_DONE;
                  end else begin
                     round_q <= round_q + 4'd1;
                  end
               end
            end
            default: fsm_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.o_busy       = in_init | in_round;
   assign bus.o_done       = (fsm_q == ST_DONE);
   assign bus.o_plain      = state_q;
   assign bus.o_round_data = state_q;
   assign bus.o_ark_data   = ark_out;
   assign bus.o_state      = in_round ? {1'b1, round_q} : 5'b00000;

endmodule

// File: tb/tb_inv_round_sequencer.sv
// Directed self-checking bench for inv_round_sequencer with a behavioural AES inverse datapath and key store.
module tb_inv_round_sequencer;
   import aes_pkg::*;

   localparam aes_block_t KEY_C1   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam aes_block_t CT_C1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam aes_block_t PT_C1    = 128'h00112233445566778899aabbccddeeff;
   localparam aes_block_t CT_OTHER = 128'hdeadbeef0123456789abcdeffedcba98;

   logic clk = 1'b0;
   logic n_rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   gcyc = 0;

   aes_block_t rk [0:10];
   logic [3:0] idx_log [$];
   logic [4:0] st_log [$];

   inv_round_sequencer_if bus ();

   inv_round_sequencer dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] bse;
      logic [7:0] e;
      r   = 8'h01;
      bse = a;
      e   = 8'd254;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = gmul(r, bse);
         bse = gmul(bse, bse);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [7:0] sb(input logic [7:0] a);
      logic [7:0] v;
      v = ginv(a);
      return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] isb(input logic [7:0] a);
      return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
   endfunction

   function automatic aes_block_t ishift(input aes_block_t b);
      aes_block_t o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127 - 8 * (r + 4 * c) -: 8] = b[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8];
      return o;
   endfunction

   function automatic aes_block_t isub(input aes_block_t b);
      aes_block_t o;
      o = '0;
      for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = isb(b[127 - 8 * i -: 8]);
      return o;
   endfunction

   function automatic aes_block_t imix(input aes_block_t b);
      aes_block_t o;
      logic [7:0] s0, s1, s2, s3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         s0 = b[127 - 32 * c -: 8];
         s1 = b[119 - 32 * c -: 8];
         s2 = b[111 - 32 * c -: 8];
         s3 = b[103 - 32 * c -: 8];
         o[127 - 32 * c -: 32] = {
            gmul(s0, 8'h0e) ^ gmul(s1, 8'h0b) ^ gmul(s2, 8'h0d) ^ gmul(s3, 8'h09),
            gmul(s0, 8'h09) ^ gmul(s1, 8'h0e) ^ gmul(s2, 8'h0b) ^ gmul(s3, 8'h0d),
            gmul(s0, 8'h0d) ^ gmul(s1, 8'h09) ^ gmul(s2, 8'h0e) ^ gmul(s3, 8'h0b),
            gmul(s0, 8'h0b) ^ gmul(s1, 8'h0d) ^ gmul(s2, 8'h09) ^ gmul(s3, 8'h0e)};
      end
      return o;
   endfunction

   function automatic aes_block_t aes_dec(input aes_block_t ct);
      aes_block_t s;
      s = ct ^ rk[10];
      for (int r = 9; r >= 1; r--) s = imix(isub(ishift(s)) ^ rk[r]);
      return isub(ishift(s)) ^ rk[0];
   endfunction

   // Key store and parent-owned inverse datapath stages.
   always_comb begin
      bus.i_key = (bus.o_key_idx <= 4'd10) ? rk[bus.o_key_idx] : '0;
   end

   always_comb begin
      bus.i_sub_data = isub(ishift(bus.o_round_data));
   end

   always_comb begin
      bus.i_mix_data = (bus.o_state[3:0] == 4'd9) ? bus.o_ark_data : imix(bus.o_ark_data);
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      gcyc++;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, 128'(bus.o_busy), 128'd0);
      chk({tag, "_done"}, 128'(bus.o_done), 128'd0);
      chk({tag, "_plain"}, bus.o_plain, 128'd0);
      chk({tag, "_round_data"}, bus.o_round_data, 128'd0);
      chk({tag, "_state"}, 128'(bus.o_state), 128'd0);
      chk({tag, "_key_idx"}, 128'(bus.o_key_idx), 128'd0);
   endtask

   // Starts a block from IDLE and steps until o_done; cycle 1 is the INIT cycle.
   task automatic run_block(input aes_block_t ct, input int init_stalls, input logic [3:0] stall_round,
                            input int round_stalls, input bit log_en, input bit intrude,
                            output int done_cyc, output int done_t);
      int         cyc;
      int         init_left;
      int         rnd_left;
      aes_block_t prev_plain;
      logic [3:0] prev_idx;
      logic [4:0] prev_state;
      init_left = init_stalls;
      rnd_left  = round_stalls;
      done_cyc  = -1;
      done_t    = -1;
      idx_log.delete();
      st_log.delete();
      bus.i_cipher    = ct;
      bus.i_key_valid = 1'b1;
      bus.i_start     = 1'b1;
      step();
      bus.i_start = 1'b0;
      cyc = 1;
      for (int n = 0; n < 40; n++) begin
         if (bus.o_done) begin
            done_cyc = cyc;
            done_t   = gcyc;
            break;
         end
         bus.i_key_valid = 1'b1;
         if (bus.o_busy && bus.o_state == 5'd0 && init_left > 0) begin
            bus.i_key_valid = 1'b0;
            init_left--;
         end else if (bus.o_state == {1'b1, stall_round} && rnd_left > 0) begin
            bus.i_key_valid = 1'b0;
            rnd_left--;
         end
         bus.i_start = intrude && (bus.o_state == 5'h13);
         if (bus.i_start) bus.i_cipher = CT_OTHER;
         if (log_en && bus.o_busy) begin
            idx_log.push_back(bus.o_key_idx);
            st_log.push_back(bus.o_state);
         end
         if (log_en && bus.o_state == 5'h10)
            chk("ark_round0", bus.o_ark_data, isub(ishift(bus.o_round_data)) ^ rk[9]);
         prev_plain = bus.o_plain;
         prev_idx   = bus.o_key_idx;
         prev_state = bus.o_state;
         step();
         cyc++;
         bus.i_start = 1'b0;
         if (!bus.i_key_valid) begin
            chk("stall_plain", bus.o_plain, prev_plain);
            chk("stall_key_idx", 128'(bus.o_key_idx), 128'(prev_idx));
            chk("stall_state", 128'(bus.o_state), 128'(prev_state));
         end
      end
      bus.i_key_valid = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      int          dc, dt, dc2, dt2, found;
      aes_block_t  held;

      bus.i_start     = 1'b0;
      bus.i_cipher    = '0;
      bus.i_key_valid = 1'b1;

      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = KEY_C1[127 - 32 * i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i - 1];
         if (i % 4 == 0) begin
            t  = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h000000};
            rc = xt(rc);
         end
         w[i] = w[i - 4] ^ t;
      end
      for (int k = 0; k < 11; k++) rk[k] = {w[4 * k], w[4 * k + 1], w[4 * k + 2], w[4 * k + 3]};

      // Power-on reset.
      #3 n_rst = 1'b0;
      #1;
      chk_reset_outputs("reset");
      step();
      step();
      n_rst = 1'b1;
      step();

      // FIPS-197 C.1 with the key always valid; trace index and round state.
      run_block(CT_C1, 0, 4'd0, 0, 1'b1, 1'b0, dc, dt);
      chk("c1_latency", 128'(dc), 128'd12);
      chk("c1_plain", bus.o_plain, PT_C1);
      chk("c1_busy_in_done", 128'(bus.o_busy), 128'd0);
      chk("c1_trace_len", 128'(idx_log.size()), 128'd11);
      for (int i = 0; i < idx_log.size() && i < 11; i++) begin
         chk("c1_key_idx_seq", 128'(idx_log[i]), 128'(10 - i));
         chk("c1_state_seq", 128'(st_log[i]), (i == 0) ? 128'd0 : 128'(8'h10 + i - 1));
      end
      step();
      chk("c1_done_single", 128'(bus.o_done), 128'd0);
      chk("c1_state_idle", 128'(bus.o_state), 128'd0);
      chk("c1_plain_held", bus.o_plain, PT_C1);

      // Stalls: three cycles in INIT, two in round 4.
      run_block(CT_C1, 3, 4'd4, 2, 1'b0, 1'b0, dc, dt);
      chk("stall_latency", 128'(dc), 128'd17);
      chk("stall_plain_result", bus.o_plain, PT_C1);
      step();

      // i_start pulsed in round 3 and again during DONE.
      run_block(CT_C1, 0, 4'd0, 0, 1'b0, 1'b1, dc, dt);
      chk("intrude_latency", 128'(dc), 128'd12);
      chk("intrude_plain", bus.o_plain, PT_C1);
      bus.i_cipher = CT_OTHER;
      bus.i_start  = 1'b1;
      step();
      bus.i_start = 1'b0;
      chk("done_start_busy", 128'(bus.o_busy), 128'd0);
      chk("done_start_done", 128'(bus.o_done), 128'd0);
      chk("done_start_plain", bus.o_plain, PT_C1);
      step();
      chk("done_start_busy2", 128'(bus.o_busy), 128'd0);
      chk("done_start_done2", 128'(bus.o_done), 128'd0);

      // Asynchronous reset during round 6, then a fresh run.
      bus.i_cipher = CT_C1;
      bus.i_start  = 1'b1;
      step();
      bus.i_start = 1'b0;
      found = 0;
      for (int n = 0; n < 20; n++) begin
         if (bus.o_state == 5'h16) begin
            found = 1;
            break;
         end
         step();
      end
      chk("abort_reached_round6", 128'(found), 128'd1);
      n_rst = 1'b0;
      #1;
      chk_reset_outputs("abort");
      step();
      chk("abort_no_done1", 128'(bus.o_done), 128'd0);
      step();
      n_rst = 1'b1;
      step();
      chk("abort_no_done2", 128'(bus.o_done), 128'd0);
      chk("abort_idle_busy", 128'(bus.o_busy), 128'd0);
      run_block(CT_C1, 0, 4'd0, 0, 1'b0, 1'b0, dc, dt);
      chk("rerun_latency", 128'(dc), 128'd12);
      chk("rerun_plain", bus.o_plain, PT_C1);
      step();

      // Back-to-back: C.1 then all-zero ciphertext, start in the first IDLE cycle.
      run_block(CT_C1, 0, 4'd0, 0, 1'b0, 1'b0, dc, dt);
      chk("b2b_first_plain", bus.o_plain, PT_C1);
      step();
      held = bus.o_plain;
      chk("b2b_idle_plain", held, PT_C1);
      run_block('0, 0, 4'd0, 0, 1'b0, 1'b0, dc2, dt2);
      chk("b2b_second_latency", 128'(dc2), 128'd12);
      chk("b2b_spacing", 128'(dt2 - dt), 128'd13);
      chk("b2b_second_plain", bus.o_plain, aes_dec('0));
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inv_round_sequencer.md
# inv_round_sequencer

Iterative control and state-holding stage for the AES-128 inverse cipher. It sits directly upstream of the inverse mix-columns stage and drives its 5-bit round state. Each round it XORs the round key with the InvShiftRows/InvSubBytes result, presents the sum to inverse mix-columns and registers what comes back. It owns the 128-bit state register, the round counter, the round-key request handshake and the start/done handshake.

## Interface
- No parameters; all constants come from the shared package.
- clk  input  1  system clock, all state on rising edge
- n_rst  input  1  asynchronous active-low reset
- i_start  input  1  request to decrypt i_cipher; sampled only in IDLE
- i_cipher  input  128  ciphertext block, byte 0 in [127:120]
- o_busy  output  1  high in INIT and ROUND
- o_done  output  1  one-cycle pulse in DONE
- o_plain  output  128  plaintext; equals the state register
- o_key_idx  output  4  round-key index requested from the key store
- i_key  input  128  round key for o_key_idx
- i_key_valid  input  1  i_key is valid this cycle; low stalls the sequencer
- o_round_data  output  128  state register, feeds the InvShiftRows→InvSubBytes chain
- i_sub_data  input  128  InvSubBytes(InvShiftRows(o_round_data)), combinational return
- o_ark_data  output  128  i_sub_data ^ i_key, drives inverse mix-columns i_data
- o_state  output  5  drives inverse mix-columns i_state; {1'b1, round} in ROUND, else 5'b00000
- i_mix_data  input  128  inverse mix-columns o_data; passes through when o_state[3:0]==9

## Operation
- FSM states: IDLE, INIT, ROUND, DONE.
- **IDLE**
  - i_start=1 → INIT; state register ← i_cipher; round ← 0.
- **INIT**
  - o_key_idx = 10.
  - On a cycle with i_key_valid=1: state ← state ^ i_key; → ROUND.
- **ROUND** (round r = 0..9)
  - o_key_idx = 9 − r; o_state = {1, r}.
  - On a cycle with i_key_valid=1: state ← i_mix_data.
    - r < 9: r ← r+1.
    - r = 9: → DONE.
  - Round 9 is the final round: inverse mix-columns bypasses, so the state receives ARK only.
- **DONE**
  - o_done=1 for one cycle; → IDLE unconditionally.
  - i_start is not sampled in DONE.
- o_plain always equals the state register. Plaintext remains valid from DONE until the next accepted i_start.
- i_key_valid=0 in INIT or ROUND: hold state, round counter and o_key_idx; no register updates.
- i_start is ignored in INIT, ROUND and DONE; no queueing.
- o_ark_data is purely combinational, i_sub_data ^ i_key, valid whenever i_key_valid=1.
- All XORs are 128-bit and bitwise; no width changes anywhere.

## Timing
- Reset values: FSM=IDLE, state register=0, round=0.
  - o_busy=0, o_done=0, o_plain=0, o_round_data=0.
  - o_state=0, o_key_idx=0 (IDLE drives index 0).
- Asserting n_rst mid-operation returns to IDLE immediately (asynchronous). No o_done is produced for the aborted block.
- Latency with i_key_valid held high:
  - i_start sampled at edge t.
  - INIT during cycle t+1.
  - ROUND 0..9 during cycles t+2..t+11.
  - o_done high during cycle t+12, o_plain valid in the same cycle.
- Total latency is 12 cycles from the start edge to the done cycle, plus one cycle per stalled cycle.
- Earliest next start is sampled at the edge ending the first IDLE cycle after DONE.
- The key store returns i_key combinationally for o_key_idx. o_key_idx changes only at a clock edge.

## Structure
- Shared package aes_pkg holds:
  - FSM enum typedef inv_seq_state_t {IDLE, INIT, ROUND, DONE}.
  - localparams NUM_ROUNDS=10, LAST_ROUND=4'd9, INIT_KEY_IDX=4'd10.
  - typedef aes_block_t = logic [127:0].
- Sub-module add_round_key: combinational 128-bit XOR of data and key. This module instantiates it once, producing o_ark_data. The INIT XOR reuses it with o_round_data muxed onto its data input.
- The inverse datapath stages are instantiated by the parent, not inside this block: inverse shift rows, inverse sub bytes, inverse mix columns.

## Test plan
- Run the FIPS-197 C.1 vector with i_key_valid always 1, using key 000102030405060708090a0b0c0d0e0f expanded by the bench.
  - Start with i_cipher=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: o_done exactly 12 cycles after the start edge; o_plain=00112233445566778899aabbccddeeff.
- Record o_state and o_key_idx during the same run.
  - Required o_key_idx sequence: 10,9,…,0.
  - Required o_state sequence: 0x10..0x19, with 0x19 on the final round; otherwise 0x00.
- Drop i_key_valid for 3 cycles in INIT and 2 cycles in round 4.
  - Required: done at 17 cycles with the same plaintext; state and index frozen while stalled.
- Pulse i_start with a different ciphertext during round 3 and again during DONE.
  - Required: both ignored; first result unchanged; single o_done pulse.
- Assert n_rst low in round 6, release it, then start the C.1 vector again.
  - Required: all outputs 0 during reset; no o_done from the aborted run; correct plaintext from the new run.
- Run back-to-back blocks: the C.1 ciphertext, then all-zero ciphertext, with start asserted in the first IDLE cycle after DONE.
  - Required: two done pulses 13 cycles apart; second o_plain matches the bench reference model.
